// File: rtl/reg_file_pkg.sv
// Shared constants and types for the 32 x 32-bit register file.
package reg_file_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    localparam reg_addr_t ZERO_REG = '0;
endpackage

// File: rtl/reg_file32_if.sv
// Read/write/reserve bus of the register file.
// master = datapath (issue + writeback), slave = register file.
interface reg_file32_if;
    import reg_file_pkg::*;

    reg_addr_t rs1_addr;
    reg_data_t rs1_data;
    logic      rs1_busy;
    reg_addr_t rs2_addr;
    reg_data_t rs2_data;
    logic      rs2_busy;
    logic      wr_en;
    reg_addr_t wr_addr;
    reg_data_t wr_data;
    logic      rsv_en;
    reg_addr_t rsv_addr;
    logic      hazard;

    modport master (
        output rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        input  rs1_data, rs1_busy, rs2_data, rs2_busy, hazard
    );

    modport slave (
        input  rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        output rs1_data, rs1_busy, rs2_data, rs2_busy, hazard
    );
endinterface

// File: rtl/reg32.sv
// 32-bit storage cell with load enable and async active-low clear.
module reg32
    import reg_file_pkg::*;
(
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  logic      i_en,
    input  reg_data_t i_d,
    output reg_data_t o_q
);
    reg_data_t r_q;

    // Load on enable, clear on reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)  r_q <= '0;
        else if (i_en) r_q <= i_d;
    end

    assign o_q = r_q;
endmodule

// File: rtl/reg_file_scoreboard.sv
// Per-register busy bits for RAW hazard detection.
// A reservation beats a same-cycle writeback to the same register, since
// the reserving instruction is the newer producer.
// With REG_FILE_BYPASS_EN, a writeback hitting a read port clears that
// port's busy in the same cycle unless the register is also re-reserved.
module reg_file_scoreboard
    import reg_file_pkg::*;
(
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  logic      i_rsv_en,
    input  reg_addr_t i_rsv_addr,
    input  logic      i_wr_en,
    input  reg_addr_t i_wr_addr,
    input  reg_addr_t i_rs1_addr,
    input  reg_addr_t i_rs2_addr,
    output logic      o_rs1_busy,
    output logic      o_rs2_busy
);
    logic [NUM_REGS-1:0] r_busy;

    // Reserve sets, writeback clears, reserve has priority; busy[0] stays 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy[0] <= 1'b0;
            for (int r = 1; r < NUM_REGS; r++) begin
                if (i_rsv_en && i_rsv_addr == reg_addr_t'(r))
                    r_busy[r] <= 1'b1;
                else if (i_wr_en && i_wr_addr == reg_addr_t'(r))
                    r_busy[r] <= 1'b0;
            end
        end
    end

`ifdef REG_FILE_BYPASS_EN
    logic w_wr_hit1, w_wr_hit2, w_rsv_hit1, w_rsv_hit2;
    assign w_wr_hit1  = i_wr_en  && (i_wr_addr  != ZERO_REG) && (i_wr_addr  == i_rs1_addr);
    assign w_wr_hit2  = i_wr_en  && (i_wr_addr  != ZERO_REG) && (i_wr_addr  == i_rs2_addr);
    assign w_rsv_hit1 = i_rsv_en && (i_rsv_addr != ZERO_REG) && (i_rsv_addr == i_rs1_addr);
    assign w_rsv_hit2 = i_rsv_en && (i_rsv_addr != ZERO_REG) && (i_rsv_addr == i_rs2_addr);
    assign o_rs1_busy = w_wr_hit1 ? w_rsv_hit1 : r_busy[i_rs1_addr];
    assign o_rs2_busy = w_wr_hit2 ? w_rsv_hit2 : r_busy[i_rs2_addr];
`else
    assign o_rs1_busy = r_busy[i_rs1_addr];
    assign o_rs2_busy = r_busy[i_rs2_addr];
`endif
endmodule

// File: rtl/reg_file32.sv
// 32 x 32-bit register file: two combinational read ports, one synchronous
// write port, busy scoreboard. Register 0 reads as zero.
// Optional macro REG_FILE_BYPASS_EN forwards same-cycle writeback data and
// busy-clear to the read ports.
module reg_file32
    import reg_file_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    reg_file32_if.slave bus
);
    reg_data_t w_regs [NUM_REGS];
    reg_data_t w_rd1, w_rd2;

    assign w_regs[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
            reg32 u_reg (
                .i_clk   (clk),
                .i_rst_n (rst),
                .i_en    (bus.wr_en && bus.wr_addr == reg_addr_t'(gi)),
                .i_d     (bus.wr_data),
                .o_q     (w_regs[gi])
            );
        end
    endgenerate

    assign w_rd1 = w_regs[bus.rs1_addr];
    assign w_rd2 = w_regs[bus.rs2_addr];

`ifdef REG_FILE_BYPASS_EN
    logic w_byp1, w_byp2;
    assign w_byp1       = bus.wr_en && (bus.wr_addr != ZERO_REG) && (bus.wr_addr == bus.rs1_addr);
    assign w_byp2       = bus.wr_en && (bus.wr_addr != ZERO_REG) && (bus.wr_addr == bus.rs2_addr);
    assign bus.rs1_data = w_byp1 ? bus.wr_data : w_rd1;
    assign bus.rs2_data = w_byp2 ? bus.wr_data : w_rd2;
`else
    assign bus.rs1_data = w_rd1;
    assign bus.rs2_data = w_rd2;
`endif

    logic w_rs1_busy, w_rs2_busy;

    reg_file_scoreboard u_sb (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_rsv_en   (bus.rsv_en),
        .i_rsv_addr (bus.rsv_addr),
        .i_wr_en    (bus.wr_en),
        .i_wr_addr  (bus.wr_addr),
        .i_rs1_addr (bus.rs1_addr),
        .i_rs2_addr (bus.rs2_addr),
        .o_rs1_busy (w_rs1_busy),
        .o_rs2_busy (w_rs2_busy)
    );

    assign bus.rs1_busy = w_rs1_busy;
    assign bus.rs2_busy = w_rs2_busy;
    assign bus.hazard   = w_rs1_busy | w_rs2_busy;
endmodule
